// File: rtl/adder41_arbiter_if.sv
// Request/response bundle for the shared 41+15 bit adder arbiter.
// slave = the arbiter's view; master = requesters plus response consumer.
interface adder41_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 41,
    parameter int B_W     = 15,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [A_W:0]           rsp_sum;
    logic [ID_W-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/adder41_arbiter.sv
// Round-robin shared A + zext(B) adder with one registered, id-tagged response slot.
// Define ADDER41_ARB_STATS_EN to add accept_count/stall_count outputs.
module adder41_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 41,
    parameter int B_W     = 15,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adder41_arbiter_if.slave    bus,
`ifdef ADDER41_ARB_STATS_EN
    output logic [15:0]         accept_count,
    output logic [15:0]         stall_count,
`endif
    output logic                busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [A_W:0]    rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            slot_free;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [A_W-1:0]  sel_a;
    logic [B_W-1:0]  sel_b;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && bus.req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    assign slot_free = (state_q == EMPTY) | ((state_q == FULL) & bus.rsp_ready);
    // Gating with rst_n keeps req_ready low while reset is held
    assign accept    = grant_vld & slot_free & rst_n;

    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    assign sel_a = bus.req_a[int'(grant_idx)*A_W +: A_W];
    assign sel_b = bus.req_b[int'(grant_idx)*B_W +: B_W];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        if (accept) begin
            state_d   = FULL;
            rsp_sum_d = {1'b0, sel_a} + {{(A_W+1-B_W){1'b0}}, sel_b};
            rsp_id_d  = grant_idx;
            rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state_q == FULL) | (|bus.req_valid);

`ifdef ADDER41_ARB_STATS_EN
    logic [15:0] accept_count_q, accept_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    // accept_count wraps; stall_count saturates
    always_comb begin
        accept_count_d = accept ? accept_count_q + 16'd1 : accept_count_q;
        stall_count_d  = stall_count_q;
        if ((state_q == FULL) && !bus.rsp_ready && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            accept_count_q <= accept_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign accept_count = accept_count_q;
    assign stall_count  = stall_count_q;
`endif

endmodule
